// File: rtl/axi_dbg_pkg.sv
// axi_dbg_pkg: shared states, AXI response codes and debug-space addresses
// for the axi_dbg_master single-beat AXI4 initiator.
package axi_dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_B,
    S_RD_A,
    S_RD_R,
    S_RSP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] UART_TX        = 32'h2000_0000;
  localparam logic [31:0] TIMER          = 32'h2000_0008;
  localparam logic [31:0] COTRL          = 32'h2000_0010;
  localparam logic [31:0] COTRL_COREMARK = 32'h2000_0020;

endpackage

// File: rtl/axi_dbg_wr_chan.sv
// axi_dbg_wr_chan: AW/W channel pairing; each VALID drops independently
// after its own handshake, o_done reports when both have completed.
module axi_dbg_wr_chan
  import axi_dbg_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_abort,
  input  logic i_awready,
  input  logic i_wready,
  output logic o_awvalid,
  output logic o_wvalid,
  output logic o_done
);

  logic r_awvalid;
  logic r_wvalid;
  logic r_aw_done;
  logic r_w_done;
  logic w_aw_hs;
  logic w_w_hs;

  assign w_aw_hs = r_awvalid & i_awready;
  assign w_w_hs  = r_wvalid & i_wready;

  // Done also covers a handshake landing in the current cycle.
  assign o_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

  assign o_awvalid = r_awvalid;
  assign o_wvalid  = r_wvalid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (i_start) begin
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (i_abort) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_dbg_master.sv
// axi_dbg_master: command/response to single-beat AXI4 read or write.
// Optional watchdog abort enabled by defining DBG_TIMEOUT_EN.
module axi_dbg_master
  import axi_dbg_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int IDW     = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_write,
  input  logic [AW-1:0]    i_cmd_addr,
  input  logic [DW-1:0]    i_cmd_wdata,
  input  logic [DW/8-1:0]  i_cmd_wstrb,
  input  logic [IDW-1:0]   i_cmd_id,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [DW-1:0]    o_rsp_rdata,
  output logic [1:0]       o_rsp_resp,
  output logic             o_rsp_id_err,
  output logic             o_rsp_timeout,
  output logic [IDW-1:0]   o_m_awid,
  output logic [AW-1:0]    o_m_awaddr,
  output logic             o_m_awvalid,
  input  logic             i_m_awready,
  output logic [DW-1:0]    o_m_wdata,
  output logic [DW/8-1:0]  o_m_wstrb,
  output logic             o_m_wvalid,
  input  logic             i_m_wready,
  input  logic [IDW-1:0]   i_m_bid,
  input  logic [1:0]       i_m_bresp,
  input  logic             i_m_bvalid,
  output logic             o_m_bready,
  output logic [IDW-1:0]   o_m_arid,
  output logic [AW-1:0]    o_m_araddr,
  output logic             o_m_arvalid,
  input  logic             i_m_arready,
  input  logic [IDW-1:0]   i_m_rid,
  input  logic [DW-1:0]    i_m_rdata,
  input  logic [1:0]       i_m_rresp,
  input  logic             i_m_rvalid,
  output logic             o_m_rready
);

  state_e              r_state;
  logic                r_cmd_ready;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;
  logic [DW/8-1:0]     r_wstrb;
  logic [IDW-1:0]      r_id;
  logic                r_arvalid;
  logic                r_bready;
  logic                r_rready;
  logic                r_rsp_valid;
  logic [DW-1:0]       r_rsp_rdata;
  logic [1:0]          r_rsp_resp;
  logic                r_rsp_id_err;
  logic                r_rsp_timeout;
  logic                w_accept;
  logic                w_wr_start;
  logic                w_wr_done;
  logic                w_expire;

  assign w_accept   = r_cmd_ready & i_cmd_valid;
  assign w_wr_start = w_accept & i_cmd_write;

`ifdef DBG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          w_busy;
  logic          w_adv;

  assign w_busy = (r_state == S_WR) | (r_state == S_WR_B) |
                  (r_state == S_RD_A) | (r_state == S_RD_R);
  // Any state-advancing handshake beats expiry in the same cycle.
  assign w_adv = ((r_state == S_WR) & w_wr_done) |
                 ((r_state == S_WR_B) & i_m_bvalid & r_bready) |
                 ((r_state == S_RD_A) & i_m_arready & r_arvalid) |
                 ((r_state == S_RD_R) & i_m_rvalid & r_rready);
  assign w_expire = w_busy & ~w_adv &
                    (r_tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || w_adv || !w_busy) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT == 0);
  assign w_expire     = 1'b0;
`endif

  axi_dbg_wr_chan u_wr_chan (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_wr_start),
    .i_abort   (w_expire),
    .i_awready (i_m_awready),
    .i_wready  (i_m_wready),
    .o_awvalid (o_m_awvalid),
    .o_wvalid  (o_m_wvalid),
    .o_done    (w_wr_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b1;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_id          <= '0;
      r_arvalid     <= 1'b0;
      r_bready      <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= RESP_OKAY;
      r_rsp_id_err  <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else if (w_expire) begin
      r_arvalid     <= 1'b0;
      r_bready      <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= RESP_SLVERR;
      r_rsp_id_err  <= 1'b0;
      r_rsp_timeout <= 1'b1;
      r_state       <= S_RSP;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr        <= i_cmd_addr;
            r_wdata       <= i_cmd_wdata;
            r_wstrb       <= i_cmd_wstrb;
            r_id          <= i_cmd_id;
            r_cmd_ready   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            if (i_cmd_write) begin
              r_state <= S_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_A;
            end
          end
        end
        S_WR: begin
          if (w_wr_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_B;
          end
        end
        S_WR_B: begin
          if (i_m_bvalid && r_bready) begin
            r_bready     <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_rdata  <= '0;
            r_rsp_resp   <= i_m_bresp;
            r_rsp_id_err <= (i_m_bid != r_id);
            r_state      <= S_RSP;
          end
        end
        S_RD_A: begin
          if (i_m_arready && r_arvalid) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_R;
          end
        end
        S_RD_R: begin
          if (i_m_rvalid && r_rready) begin
            r_rready     <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_rdata  <= i_m_rdata;
            r_rsp_resp   <= i_m_rresp;
            r_rsp_id_err <= (i_m_rid != r_id);
            r_state      <= S_RSP;
          end
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_resp    = r_rsp_resp;
  assign o_rsp_id_err  = r_rsp_id_err;
  assign o_rsp_timeout = r_rsp_timeout;
  assign o_m_awid      = r_id;
  assign o_m_awaddr    = r_addr;
  assign o_m_wdata     = r_wdata;
  assign o_m_wstrb     = r_wstrb;
  assign o_m_bready    = r_bready;
  assign o_m_arid      = r_id;
  assign o_m_araddr    = r_addr;
  assign o_m_arvalid   = r_arvalid;
  assign o_m_rready    = r_rready;

endmodule

// File: doc/axi_dbg_master.md
Name: axi_dbg_master

Overview:
- AXI4 single-beat initiator for the debug/testbench address space (UART_TX 0x2000_0000, TIMER 0x2000_0008, COTRL 0x2000_0010, COTRL_COREMARK 0x2000_0020).
- Converts a simple command handshake into one AXI read or write transaction.
- Drives the debug responder's slave port.
- Returns response data and status through a response handshake.

Parameters:
- AW, 32, address width
- DW, 64, data width; WSTRB width is DW/8
- IDW, 4, AXI ID width
- TIMEOUT, 1024, cycles to wait for AWREADY/WREADY/BVALID/ARREADY/RVALID before abort; used only with the optional feature

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous active-high reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  block idle, command accepted this cycle when both high
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  AW  target address
- CMD_WDATA  in  DW  write data
- CMD_WSTRB  in  DW/8  write strobes
- CMD_ID  in  IDW  transaction ID
- RSP_VALID  out  1  response available
- RSP_READY  in  1  response consumer ready
- RSP_RDATA  out  DW  read data; 0 for writes
- RSP_RESP  out  2  BRESP/RRESP copy, or 2'b10 on timeout
- RSP_ID_ERR  out  1  returned BID/RID differed from issued ID
- RSP_TIMEOUT  out  1  transaction aborted by watchdog
- M_AWID/M_AWADDR/M_AWVALID out, M_AWREADY in: AXI write-address channel
- M_WDATA/M_WSTRB/M_WVALID out, M_WREADY in: AXI write-data channel (WLAST tied 1 externally)
- M_BID/M_BRESP/M_BVALID in, M_BREADY out: AXI write-response channel
- M_ARID/M_ARADDR/M_ARVALID out, M_ARREADY in: AXI read-address channel
- M_RID/M_RDATA/M_RRESP/M_RVALID in, M_RREADY out: AXI read-data channel

Behaviour:
- Clocking and reset: one clock CLK; reset RST is synchronous, active-high.
- Reset values: state IDLE; all VALID/READY outputs 0 except CMD_READY = 1; RSP_* = 0; AXI address/data/ID outputs = 0.
- States: IDLE, WR (AW+W), WR_B, RD_A, RD_R, RSP.
- IDLE: CMD_READY = 1. On CMD_VALID & CMD_READY:
  - latch addr, data, strb, id, write;
  - write goes to WR, asserting AWVALID and WVALID together next cycle;
  - read goes to RD_A, asserting ARVALID next cycle.
  - Command-to-VALID latency is 1 cycle.
- WR: AW and W complete independently.
  - Track aw_done and w_done flags.
  - Deassert each VALID the cycle after its own handshake.
  - Enter WR_B when both are done, including when both handshake in the same cycle.
  - VALID stays stable until READY and is never withdrawn; address, data and ID are held stable while VALID is high.
- WR_B: BREADY = 1.
  - On BVALID, capture BRESP, set id_err = (BID != latched id) and go to RSP.
  - RSP_RDATA = 0 for writes.
- RD_A: ARVALID held until ARREADY, then go to RD_R.
- RD_R: RREADY = 1.
  - On RVALID, capture RDATA, RRESP and id check, then go to RSP.
- RSP: RSP_VALID = 1 with fields stable until RSP_READY; then return to IDLE.
  - CMD_READY reasserts in the cycle after the RSP handshake, so there is no command/response overlap.
  - Throughput is one outstanding transaction.
- BREADY/RREADY are asserted only in WR_B/RD_R. A BVALID or RVALID arriving in any other state is ignored and not accepted.
- RST asserted mid-transaction: all VALIDs drop next edge and state returns to IDLE. The responder is expected to be reset alongside.
- A command presented while not in IDLE is not accepted; CMD_READY = 0.

Optional Feature:
- Macro: DBG_TIMEOUT_EN.
- With it defined:
  - A counter (width $clog2(TIMEOUT+1)) clears on entry to WR/WR_B/RD_A/RD_R and increments every cycle in those states.
  - When it reaches TIMEOUT, all AXI VALID/READY outputs drop and the block goes to RSP with RSP_TIMEOUT = 1, RSP_RESP = 2'b10 and RSP_RDATA = 0.
  - A handshake completing in the same cycle as expiry takes priority, and no timeout is reported.
- Without it: no counter; RSP_TIMEOUT is tied 0; the block waits indefinitely.

Decomposition:
- Package axi_dbg_pkg holds:
  - state enum;
  - AXI resp constants OKAY = 2'b00, SLVERR = 2'b10;
  - debug address constants UART_TX, TIMER, COTRL, COTRL_COREMARK.
- One natural sub-module: axi_dbg_wr_chan, the AW/W pairing with independent done flags.
- Read path and response register stay in the top.

Test Plan:
- Write to UART_TX, data 0x41, strb 0xFF, responder ready immediately → AWVALID/WVALID rise 1 cycle after command, drop after handshake; RSP_RESP = 00, RSP_RDATA = 0.
- Write to TIMER, data 1, AWREADY delayed 3 cycles and WREADY delayed 1 → WVALID drops first, AWVALID held 3 cycles; exactly one B accepted; response OKAY.
- Read of 0x2000_0008 with ID 5, RVALID delayed 4 cycles, RID 5, RDATA 0xDEAD_BEEF → RSP_RDATA = 0xDEAD_BEEF, RSP_ID_ERR = 0.
- Write with ID 3 where the responder returns BID 2 and BRESP 2'b10 → RSP_RESP = 10, RSP_ID_ERR = 1.
- RSP_READY held low for 5 cycles → RSP fields stable, CMD_READY = 0 throughout; next command accepted 1 cycle after the handshake.
- DBG_TIMEOUT_EN with TIMEOUT = 16 and ARREADY never asserted → ARVALID drops after 16 cycles; RSP_TIMEOUT = 1, RSP_RESP = 10. RST pulse in RD_R → IDLE next cycle, all VALIDs 0.
